dly_cal_ctl: RTL and testbench

Calibration controller for the generic-cell inverter-chain delay line. It drives the line's tap select and runs a successive-approximation search against a synchronized phase-detector input. When the search finishes it holds the resulting tap. With tracking compiled in, it then nudges the tap by ±1 at a fixed interval. It sits between the delay-line tap mux and the block that requests calibration.

---
 rtl/dly_cal_pkg.sv | 20 ++
 rtl/dly_cal_tmr.sv | 27 ++
 rtl/dly_cal_ctl.sv | 147 ++++++++++++++
 tb/tb_dly_cal_ctl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dly_cal_pkg.sv
// Shared types and helpers for the delay-line calibration controller.
package dly_cal_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    LOCK
  } dly_cal_state_t;

  // Number of bits needed to hold the value v (at least 1).
  function automatic int unsigned width_of(input int unsigned v);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((v >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dly_cal_tmr.sv
// Loadable down-counter; o_tc flags an enabled cycle with the count at zero.
module dly_cal_tmr #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_tc = i_en && (r_cnt == '0);

endmodule

// File: rtl/dly_cal_ctl.sv
// SAR tap calibration for the inverter-chain delay line.
// Define DLY_CAL_TRACK_EN to add +/-1 tap tracking while locked.
module dly_cal_ctl
  import dly_cal_pkg::*;
#(
  parameter int unsigned NTAP_W    = 5,
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned TRACK_PER = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              early,
  output logic [NTAP_W-1:0] tap,
  output logic              busy,
  output logic              done,
  output logic              lock,
  output logic              err
);

  localparam int unsigned IDX_W = width_of(NTAP_W - 1);
`ifdef DLY_CAL_TRACK_EN
  localparam int unsigned CNT_W = width_of(((SETTLE > TRACK_PER) ? SETTLE : TRACK_PER) - 1);
  localparam logic [CNT_W-1:0] TRK_LD = CNT_W'(TRACK_PER - 1);
`else
  localparam int unsigned CNT_W = width_of(SETTLE - 1);
`endif
  localparam logic [CNT_W-1:0]  SET_LD  = CNT_W'(SETTLE - 1);
  localparam logic [NTAP_W-1:0] TAP_MID = NTAP_W'(1) << (NTAP_W - 1);
  localparam logic [IDX_W-1:0]  BIT_TOP = IDX_W'(NTAP_W - 1);

  dly_cal_state_t    r_state, w_state_n;
  logic [NTAP_W-1:0] r_tap, w_tap_n, w_dec;
  logic [IDX_W-1:0]  r_bit, w_bit_n, w_bit_m1;
  logic              r_busy, w_busy_n;
  logic              r_done, w_done_n;
  logic              r_lock, w_lock_n;
  logic              r_err, w_err_n;
  logic              w_ld, w_en, w_tc;
  logic [CNT_W-1:0]  w_ld_val;

  dly_cal_tmr #(.W(CNT_W)) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_ld),
    .i_val  (w_ld_val),
    .i_en   (w_en),
    .o_tc   (w_tc)
  );

  // Current trial tap with the bit under test resolved by the detector.
  always_comb begin
    w_dec        = r_tap;
    w_dec[r_bit] = early;
    w_bit_m1     = r_bit - IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tap   <= '0;
      r_bit   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_lock  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_tap   <= w_tap_n;
      r_bit   <= w_bit_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_lock  <= w_lock_n;
      r_err   <= w_err_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_tap_n   = r_tap;
    w_bit_n   = r_bit;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_lock_n  = r_lock;
    w_err_n   = r_err;
    w_ld      = 1'b0;
    w_ld_val  = SET_LD;
    w_en      = 1'b0;
    case (r_state)
      IDLE, LOCK: begin
        if (start) begin
          w_state_n = SEARCH;
          w_tap_n   = TAP_MID;
          w_bit_n   = BIT_TOP;
          w_busy_n  = 1'b1;
          w_lock_n  = 1'b0;
          w_err_n   = 1'b0;
          w_ld      = 1'b1;
        end
`ifdef DLY_CAL_TRACK_EN
        else if (r_state == LOCK) begin
          w_en = 1'b1;
          if (w_tc) begin
            w_ld     = 1'b1;
            w_ld_val = TRK_LD;
            if (early) begin
              if (r_tap == '1) w_err_n = 1'b1;
              else             w_tap_n = r_tap + NTAP_W'(1);
            end else begin
              if (r_tap == '0) w_err_n = 1'b1;
              else             w_tap_n = r_tap - NTAP_W'(1);
            end
          end
        end
`endif
      end
      SEARCH: begin
        w_en = 1'b1;
        if (w_tc) begin
          w_tap_n = w_dec;
          w_ld    = 1'b1;
          if (r_bit != '0) begin
            w_tap_n[w_bit_m1] = 1'b1;
            w_bit_n           = w_bit_m1;
          end else begin
            w_state_n = LOCK;
            w_busy_n  = 1'b0;
            w_lock_n  = 1'b1;
            w_done_n  = 1'b1;
            w_err_n   = (w_dec == '0) || (w_dec == '1);
`ifdef DLY_CAL_TRACK_EN
            w_ld_val  = TRK_LD;
`endif
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign tap  = r_tap;
  assign busy = r_busy;
  assign done = r_done;
  assign lock = r_lock;
  assign err  = r_err;

endmodule

// File: tb/tb_dly_cal_ctl.sv
// Self-checking bench for dly_cal_ctl against a cycle-count search model.
module tb_dly_cal_ctl;

  localparam int unsigned NW   = 5;
  localparam int unsigned ST   = 4;
  localparam int unsigned TP   = 16;
  localparam int          MAXT = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          early;
  logic [NW-1:0] tap;
  logic          busy, done, lock, err;

  always #5 clk = ~clk;

  dly_cal_ctl #(.NTAP_W(NW), .SETTLE(ST), .TRACK_PER(TP)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .early (early),
    .tap   (tap),
    .busy  (busy),
    .done  (done),
    .lock  (lock),
    .err   (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Phase detector: threshold on the live tap, stuck values, or random.
  int   mode = 0;
  int   thr  = 19;
  logic rnd_bit = 1'b0;
  always @(negedge clk) rnd_bit = 1'($urandom_range(0, 1));
  always_comb begin
    case (mode)
      0:       early = (int'(tap) < thr);
      1:       early = 1'b1;
      2:       early = 1'b0;
      default: early = rnd_bit;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  int done_cyc = -1;
  always @(negedge clk) if (done === 1'b1) begin
    done_cnt++;
    done_cyc = cyc;
  end

  // Model: decision n of a search happens n*SETTLE cycles after start and
  // resolves bit NW-n; tracking acts every TP cycles after completion.
  int m_tap = 0, m_k = 0, m_tk = 0;
  bit m_busy = 0, m_lock = 0, m_err = 0, m_done = 0;
  bit cmp_en = 0;

  always @(posedge clk) begin : model
    int b;
    if (rst) begin
      m_tap = 0; m_busy = 0; m_lock = 0; m_err = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_k++;
        if (m_k % ST == 0) begin
          b = NW - m_k / ST;
          if (!early) m_tap &= ~(1 << b);
          if (b > 0) m_tap |= 1 << (b - 1);
          else begin
            m_busy = 0; m_lock = 1; m_done = 1; m_tk = 0;
            m_err  = (m_tap == 0) || (m_tap == MAXT);
          end
        end
      end else if (start) begin
        m_busy = 1; m_k = 0; m_tap = 1 << (NW - 1); m_lock = 0; m_err = 0;
      end
`ifdef DLY_CAL_TRACK_EN
      else if (m_lock) begin
        m_tk++;
        if (m_tk % TP == 0) begin
          if (early) begin
            if (m_tap < MAXT) m_tap++; else m_err = 1;
          end else begin
            if (m_tap > 0) m_tap--; else m_err = 1;
          end
        end
      end
`endif
    end
  end

  always @(negedge clk) if (cmp_en) begin
    chk("cyc_tap",  tap,  m_tap);
    chk("cyc_busy", busy, m_busy);
    chk("cyc_done", done, m_done);
    chk("cyc_lock", lock, m_lock);
    chk("cyc_err",  err,  m_err);
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) nxt();
  endtask

  // Returns with the cycle count just after the edge that sampled start.
  task automatic start_pulse(output int t0);
    start = 1'b1;
    nxt();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      nxt();
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  int t0, dc0;
  int trial_exp[5] = '{16, 24, 20, 18, 19};

  initial begin
    rst = 1'b1;
    run(2);
    cmp_en = 1;
    chk("rst_tap", tap, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_lock", lock, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    run(2);

    // Nominal search with the line crossing between taps 18 and 19.
    mode = 0; thr = 19; dc0 = done_cnt;
    start_pulse(t0);
    chk("trial0", tap, trial_exp[0]);
    chk("busy_on", busy, 1);
    for (int w = 1; w < 5; w++) begin
      run(ST);
      chk("trial", tap, trial_exp[w]);
    end
    run(ST);
    chk("nom_tap", tap, 18);
    chk("nom_model", m_tap, 18);
    chk("nom_done", done, 1);
    chk("nom_lock", lock, 1);
    chk("nom_err", err, 0);
    chk("nom_done_edge", done_cyc - t0, NW * ST);
    chk("nom_done_cnt", done_cnt - dc0, 1);
`ifdef DLY_CAL_TRACK_EN
    thr = 21;
    nxt();
    chk("nom_done_low", done, 0);
    run(TP - 1);
    chk("trk16", tap, 19);
    run(TP);
    chk("trk32", tap, 20);
    run(TP);
    chk("trk48", tap, 21);
    run(TP);
    chk("trk64", tap, 20);
    run(TP);
    chk("trk80", tap, 21);
    chk("trk_err", err, 0);
    chk("trk_lock", lock, 1);
`else
    nxt();
    chk("nom_done_low", done, 0);
    run(50);
    chk("frozen_tap", tap, 18);
    chk("frozen_lock", lock, 1);
`endif

    // Saturation at both ends; start is accepted from LOCK.
    mode = 1;
    start_pulse(t0);
    chk("sat_hi_lock_drop", lock, 0);
    wait_done("sat_hi");
    chk("sat_hi_tap", tap, MAXT);
    chk("sat_hi_err", err, 1);
    chk("sat_hi_lock", lock, 1);
    mode = 2;
    start_pulse(t0);
    chk("sat_lo_err_clr", err, 0);
    wait_done("sat_lo");
    chk("sat_lo_tap", tap, 0);
    chk("sat_lo_err", err, 1);

    // Second start while busy is ignored.
    mode = 0; thr = 19; dc0 = done_cnt;
    start_pulse(t0);
    run(4);
    start = 1'b1;
    nxt();
    start = 1'b0;
    run(15);
    chk("busy_start_done_edge", done_cyc - t0, NW * ST);
    chk("busy_start_tap", tap, 18);
    run(10);
    chk("busy_start_done_cnt", done_cnt - dc0, 1);

    // Reset mid-search abandons it without a done pulse.
    dc0 = done_cnt;
    start_pulse(t0);
    run(6);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    chk("midrst_tap", tap, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_lock", lock, 0);
    run(30);
    chk("midrst_no_done", done_cnt - dc0, 0);
    start_pulse(t0);
    wait_done("midrst_restart");
    chk("midrst_restart_tap", tap, 18);
    chk("midrst_restart_edge", done_cyc - t0, NW * ST);

    // Random starts, resets and detector behaviour under the cycle model.
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 11) == 0);
      if (start) begin
        mode = $urandom_range(0, 3);
        thr  = $urandom_range(0, 32);
      end
      nxt();
    end
    rst = 1'b0; start = 1'b0;
    run(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
